// File: rtl/alu_sequencer.sv
// Control sequencer for the SAP-3 ALU/accumulator: accepts one decoder request, fetches the operand
// onto the shared bus, strobes the ALU, and returns completion status with the ALU flags.
module alu_sequencer #(
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [1:0]            req_mode,
  input  logic [REG_ADDR_W-1:0] req_reg,
  input  logic                  req_use_carry,
  input  logic [3:0]            flags_in,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_ack,
  output logic [1:0]            bus_sel,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  load_tmp,
  output logic                  load_flags,
  output logic                  alu_commit,
  output logic [3:0]            alu_op,
  output logic                  alu_cin,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_err,
  output logic [3:0]            resp_flags
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OPERAND  = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [1:0] MODE_ACC   = 2'b00;
  localparam logic [1:0] MODE_REG   = 2'b01;
  localparam logic [1:0] MODE_MEM   = 2'b10;
  localparam logic [1:0] MODE_FLAGS = 2'b11;

  localparam logic [3:0] OP_LAST_VALID = 4'b1011;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_REG  = 2'b01;
  localparam logic [1:0] BUS_MEM  = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [1:0]            mode_q, mode_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic                  cin_q, cin_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    reg_d   = reg_q;
    cin_d   = cin_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          mode_d = req_mode;
          reg_d  = req_reg;
          cin_d  = req_use_carry ? flags_in[0] : 1'b0;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (req_op > OP_LAST_VALID) begin
            // Unsupported op: report straight away, touching neither bus nor ALU.
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            case (req_mode)
              MODE_ACC: state_d = S_EXEC;
              MODE_MEM: state_d = S_MEM_WAIT;
              default:  state_d = S_OPERAND;
            endcase
          end
        end
      end

      S_OPERAND: begin
        state_d = (mode_q == MODE_FLAGS) ? S_DONE : S_EXEC;
      end

      S_MEM_WAIT: begin
        // An ack arriving in the final allowed cycle still completes the fetch.
        if (mem_rd_ack) begin
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mode_q  <= MODE_ACC;
      reg_q   <= '0;
      cin_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      reg_q   <= reg_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_idle, in_operand, in_mem_wait, in_exec, in_done;

  always_comb begin
    in_idle     = (state_q == S_IDLE);
    in_operand  = (state_q == S_OPERAND);
    in_mem_wait = (state_q == S_MEM_WAIT);
    in_exec     = (state_q == S_EXEC);
    in_done     = (state_q == S_DONE);

    req_ready  = in_idle;
    mem_rd_req = in_mem_wait;

    bus_sel = BUS_NONE;
    if (in_operand)  bus_sel = BUS_REG;
    if (in_mem_wait) bus_sel = BUS_MEM;

    reg_addr   = in_operand ? reg_q : '0;
    load_tmp   = (in_operand && (mode_q == MODE_REG)) || (in_mem_wait && mem_rd_ack);
    load_flags = in_operand && (mode_q == MODE_FLAGS);
    alu_commit = in_exec;

    alu_op  = in_idle ? 4'b0000 : op_q;
    alu_cin = in_idle ? 1'b0    : cin_q;

    resp_valid = in_done;
    resp_err   = in_done && err_q;
    resp_flags = in_done ? flags_in : 4'b0000;
  end

  // Structural guarantees on the ALU control pins.
  a_strobes_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({load_tmp, load_flags, alu_commit}));

  a_commit_single : assert property (@(posedge clk) disable iff (!rst_n)
    alu_commit |=> !alu_commit);

  a_no_commit_on_err : assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && resp_err) |-> !alu_commit);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: each request is expanded into a per-cycle timeline of
// expected observable phases, then driven with randomized side inputs and compared cycle by cycle.
module tb_alu_sequencer;

  localparam int RW = 3;
  localparam int T  = 15;
  localparam int NEVER = 99;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [1:0]    req_mode;
  logic [RW-1:0] req_reg;
  logic          req_use_carry;
  logic [3:0]    flags_in;
  logic          mem_rd_req;
  logic          mem_rd_ack;
  logic [1:0]    bus_sel;
  logic [RW-1:0] reg_addr;
  logic          load_tmp;
  logic          load_flags;
  logic          alu_commit;
  logic [3:0]    alu_op;
  logic          alu_cin;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_err;
  logic [3:0]    resp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.REG_ADDR_W(RW), .MEM_TIMEOUT(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_mode      (req_mode),
    .req_reg       (req_reg),
    .req_use_carry (req_use_carry),
    .flags_in      (flags_in),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_ack    (mem_rd_ack),
    .bus_sel       (bus_sel),
    .reg_addr      (reg_addr),
    .load_tmp      (load_tmp),
    .load_flags    (load_flags),
    .alu_commit    (alu_commit),
    .alu_op        (alu_op),
    .alu_cin       (alu_cin),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_err      (resp_err),
    .resp_flags    (resp_flags)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_WAIT, P_ACK, P_OPER_TMP, P_OPER_FLG, P_EXEC, P_DONE} phase_e;

  // Observable outputs packed as {req_ready, mem_rd_req, bus_sel, reg_addr, load_tmp, load_flags,
  // alu_commit, alu_op, alu_cin, resp_valid, resp_err, resp_flags}.
  function automatic logic [20:0] observed();
    return {req_ready, mem_rd_req, bus_sel, reg_addr, load_tmp, load_flags,
            alu_commit, alu_op, alu_cin, resp_valid, resp_err, resp_flags};
  endfunction

  function automatic logic [20:0] expected(input phase_e ph, input logic [3:0] op, input logic cin,
                                           input logic [RW-1:0] ra, input logic err,
                                           input logic [3:0] fl);
    logic rr, mrq, lt, lf, ac, rv, re;
    logic [1:0] bus;
    logic [RW-1:0] a;
    logic [3:0] rf;
    rr = 0; mrq = 0; lt = 0; lf = 0; ac = 0; rv = 0; re = 0; bus = 2'b00; a = '0; rf = 4'b0;
    case (ph)
      P_IDLE:     rr = 1;
      P_WAIT:     begin mrq = 1; bus = 2'b10; end
      P_ACK:      begin mrq = 1; bus = 2'b10; lt = 1; end
      P_OPER_TMP: begin bus = 2'b01; a = ra; lt = 1; end
      P_OPER_FLG: begin bus = 2'b01; a = ra; lf = 1; end
      P_EXEC:     ac = 1;
      P_DONE:     begin rv = 1; re = err; rf = fl; end
      default:    rr = 1;
    endcase
    if (ph == P_IDLE) return {rr, mrq, bus, a, lt, lf, ac, 4'b0, 1'b0, rv, re, rf};
    return {rr, mrq, bus, a, lt, lf, ac, op, cin, rv, re, rf};
  endfunction

  task automatic check_idle(input string name);
    logic [20:0] exp_v, act_v;
    exp_v = expected(P_IDLE, 4'b0, 1'b0, '0, 1'b0, 4'b0);
    act_v = observed();
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s idle: got %b expected %b", name, act_v, exp_v);
    end
  endtask

  // Issue one request and follow it to the response handshake. ack_d counts MEM_WAIT cycles that
  // pass before the ack (ack lands ack_d+1 cycles after accept); rdy_d is how many DONE cycles
  // resp_ready stays low.
  task automatic run_req(input string name, input logic [3:0] op, input logic [1:0] mode,
                         input logic [RW-1:0] rg, input logic uc, input logic [3:0] fl0,
                         input int ack_d, input int rdy_d);
    phase_e q[$];
    logic err, cin;
    int commits, exp_commits, done_seen;
    logic [20:0] exp_v, act_v;

    err = 1'b0;
    cin = uc ? fl0[0] : 1'b0;
    if (op > 4'd11) begin
      err = 1'b1;
    end else begin
      case (mode)
        2'b00: q.push_back(P_EXEC);
        2'b01: begin q.push_back(P_OPER_TMP); q.push_back(P_EXEC); end
        2'b11: q.push_back(P_OPER_FLG);
        default: begin
          if (ack_d < T) begin
            for (int i = 0; i < ack_d; i++) q.push_back(P_WAIT);
            q.push_back(P_ACK);
            q.push_back(P_EXEC);
          end else begin
            for (int i = 0; i < T; i++) q.push_back(P_WAIT);
            err = 1'b1;
          end
        end
      endcase
    end
    exp_commits = 0;
    foreach (q[i]) if (q[i] == P_EXEC) exp_commits++;
    for (int i = 0; i <= rdy_d; i++) q.push_back(P_DONE);

    @(negedge clk);
    req_valid = 1; req_op = op; req_mode = mode; req_reg = rg; req_use_carry = uc;
    flags_in = fl0; mem_rd_ack = 0; resp_ready = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: req_ready got %b expected 1", name, req_ready);
    end

    commits = 0;
    done_seen = 0;
    foreach (q[k]) begin
      @(negedge clk);
      // Keep a competing request on the inputs; it must be ignored until IDLE.
      req_valid     = 1'($urandom_range(1));
      req_op        = 4'($urandom_range(15));
      req_mode      = 2'($urandom_range(3));
      req_reg       = RW'($urandom_range(7));
      req_use_carry = 1'($urandom_range(1));
      flags_in      = 4'($urandom_range(15));
      mem_rd_ack    = (mode == 2'b10 && op <= 4'd11 && k == ack_d) ? 1'b1 : 1'b0;
      if (q[k] == P_DONE) begin
        resp_ready = (done_seen == rdy_d) ? 1'b1 : 1'b0;
        done_seen++;
      end else begin
        resp_ready = 1'($urandom_range(1));
      end
      #1;
      exp_v = expected(q[k], op, cin, rg, err, flags_in);
      act_v = observed();
      if (alu_commit === 1'b1) commits++;
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle+%0d: got %b expected %b", name, k + 1, act_v, exp_v);
      end
    end

    @(negedge clk);
    req_valid = 0; mem_rd_ack = 0; resp_ready = 0;
    #1;
    check_idle(name);
    n_checks++;
    if (commits != exp_commits) begin
      n_fail++;
      $display("FAIL %s commit count: got %0d expected %0d", name, commits, exp_commits);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 0; req_op = 0; req_mode = 0; req_reg = 0; req_use_carry = 0;
    flags_in = 0; mem_rd_ack = 0; resp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_idle("reset_state");
    rst_n = 1;

    // Start a memory read, then reset in the middle of MEM_WAIT.
    @(negedge clk);
    req_valid = 1; req_op = 4'b0000; req_mode = 2'b10; req_reg = 0; flags_in = 4'b1111;
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (mem_rd_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midop pre: mem_rd_req got %b expected 1", mem_rd_req);
    end
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_idle("reset_midop_held");
    end
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_rd_ack = 1'($urandom_range(1));
      resp_ready = 1'($urandom_range(1));
      #1;
      check_idle("reset_midop_after");
    end
    mem_rd_ack = 0; resp_ready = 0;
  endtask

  task automatic test_acc_add();
    run_req("add_acc_carry", 4'b0000, 2'b00, 3'd0, 1'b1, 4'b0001, 0, 0);
    run_req("add_acc_nocarry", 4'b0001, 2'b00, 3'd0, 1'b0, 4'b0001, 0, 1);
  endtask

  task automatic test_reg_operand();
    run_req("sub_reg3", 4'b0010, 2'b01, 3'd3, 1'b0, 4'b0000, 0, 0);
    run_req("flags_load_reg5", 4'b1011, 2'b11, 3'd5, 1'b1, 4'b0001, 0, 2);
  endtask

  task automatic test_mem_operand();
    run_req("mem_ack_plus4", 4'b0100, 2'b10, 3'd0, 1'b0, 4'b0000, 3, 0);
    run_req("mem_ack_first", 4'b0011, 2'b10, 3'd0, 1'b1, 4'b0001, 0, 0);
    run_req("mem_ack_last_cycle", 4'b0101, 2'b10, 3'd0, 1'b0, 4'b0000, T - 1, 0);
    run_req("mem_ack_too_late", 4'b0101, 2'b10, 3'd0, 1'b0, 4'b0000, T, 0);
    run_req("mem_timeout", 4'b0110, 2'b10, 3'd0, 1'b0, 4'b0000, NEVER, 1);
  endtask

  task automatic test_invalid_op();
    run_req("invalid_1110", 4'b1110, 2'b00, 3'd0, 1'b1, 4'b0001, 0, 5);
    run_req("invalid_1100_mem", 4'b1100, 2'b10, 3'd2, 1'b0, 4'b0000, 0, 0);
  endtask

  task automatic test_back_to_back_random();
    logic [3:0] op;
    int ack_d;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(6) == 0) ? 4'($urandom_range(15, 12)) : 4'($urandom_range(11));
      ack_d = ($urandom_range(4) == 0) ? NEVER : int'($urandom_range(16));
      run_req($sformatf("random_%0d", i), op, 2'($urandom_range(3)), RW'($urandom_range(7)),
              1'($urandom_range(1)), 4'($urandom_range(15)), ack_d, int'($urandom_range(3)));
    end
  endtask

  initial begin
    test_reset();
    test_acc_add();
    test_reg_operand();
    test_mem_operand();
    test_invalid_op();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
